// File: rtl/nec_ir_pkg.sv
// Shared definitions for the NEC infrared decoder: FSM state encoding,
// default pulse-width windows (in ticks) and frame geometry.
// Optional feature macro used by the decoder: NEC_CHECK_EN.
package nec_ir_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEAD_LOW,
        LEAD_HIGH,
        BIT_LOW,
        BIT_HIGH,
        STOP
    } nec_state_t;

    // Default windows, one tick is about 35 us
    localparam int LEAD_LOW_MIN_DEF  = 220;
    localparam int LEAD_LOW_MAX_DEF  = 290;
    localparam int LEAD_HIGH_MIN_DEF = 110;
    localparam int LEAD_HIGH_MAX_DEF = 145;
    localparam int RPT_HIGH_MIN_DEF  = 50;
    localparam int RPT_HIGH_MAX_DEF  = 78;
    localparam int BIT_LOW_MIN_DEF   = 10;
    localparam int BIT_LOW_MAX_DEF   = 24;
    localparam int ZERO_HIGH_MIN_DEF = 10;
    localparam int ZERO_HIGH_MAX_DEF = 24;
    localparam int ONE_HIGH_MIN_DEF  = 38;
    localparam int ONE_HIGH_MAX_DEF  = 58;
    localparam int CNT_W_DEF         = 9;

    localparam int FRAME_BITS = 32;
    localparam int IDX_W      = $clog2(FRAME_BITS);

    // Inclusive window test on a measured duration
    function automatic logic in_win(input int v, input int lo, input int hi);
        return (v >= lo) && (v <= hi);
    endfunction

    // Larger of two window maxima, used for per-state timeouts
    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ir_line_sync.sv
// Brings the asynchronous IR receiver line into the clk domain with a
// two-flop synchronizer and derives single-cycle rise/fall strobes from a
// previous-value register. Flops reset high, matching an idle (no carrier)
// line, so leaving reset never fabricates an edge.
module ir_line_sync (
    input  logic clk,
    input  logic rst,
    input  logic ir_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic prev_q,  prev_d;

    // Next values of the synchronizer chain and history register
    always_comb begin
        sync1_d = ir_in;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
    end

    // Synchronizer and previous-value registers
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
        end
    end

    assign level = sync2_q;
    assign rise  = sync2_q & ~prev_q;
    assign fall  = ~sync2_q & prev_q;

endmodule

// File: rtl/nec_ir_decoder.sv
// NEC infrared frame decoder. Measures pulse widths in upstream ticks,
// walks leader / 32 data bits / stop burst, and reports decoded frames,
// repeat codes and malformed frames as single-cycle pulses.
// Build option: define NEC_CHECK_EN to require the address and command
// inverse bytes to match before a frame is accepted.
module nec_ir_decoder
    import nec_ir_pkg::*;
#(
    parameter int LEAD_LOW_MIN  = LEAD_LOW_MIN_DEF,
    parameter int LEAD_LOW_MAX  = LEAD_LOW_MAX_DEF,
    parameter int LEAD_HIGH_MIN = LEAD_HIGH_MIN_DEF,
    parameter int LEAD_HIGH_MAX = LEAD_HIGH_MAX_DEF,
    parameter int RPT_HIGH_MIN  = RPT_HIGH_MIN_DEF,
    parameter int RPT_HIGH_MAX  = RPT_HIGH_MAX_DEF,
    parameter int BIT_LOW_MIN   = BIT_LOW_MIN_DEF,
    parameter int BIT_LOW_MAX   = BIT_LOW_MAX_DEF,
    parameter int ZERO_HIGH_MIN = ZERO_HIGH_MIN_DEF,
    parameter int ZERO_HIGH_MAX = ZERO_HIGH_MAX_DEF,
    parameter int ONE_HIGH_MIN  = ONE_HIGH_MIN_DEF,
    parameter int ONE_HIGH_MAX  = ONE_HIGH_MAX_DEF,
    parameter int CNT_W         = CNT_W_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       ir_in,
    output logic [7:0] addr,
    output logic [7:0] cmd,
    output logic       data_valid,
    output logic       repeat_valid,
    output logic       frame_err
);

    // LEAD_HIGH can end as either a leader or a repeat space, BIT_HIGH as
    // either a zero or a one space, so each times out past the wider window.
    localparam int LEAD_HIGH_LIMIT = max2(LEAD_HIGH_MAX, RPT_HIGH_MAX);
    localparam int BIT_HIGH_LIMIT  = max2(ZERO_HIGH_MAX, ONE_HIGH_MAX);

    logic line_lvl, rise, fall;

    ir_line_sync u_line_sync (
        .clk   (clk),
        .rst   (rst),
        .ir_in (ir_in),
        .level (line_lvl),
        .rise  (rise),
        .fall  (fall)
    );

    nec_state_t              state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        bit_idx_q, bit_idx_d;
    logic [FRAME_BITS-1:0]   sh_q, sh_d;
    logic                    rpt_q, rpt_d;
    logic                    have_frame_q, have_frame_d;
    logic [7:0]              addr_q, addr_d;
    logic [7:0]              cmd_q, cmd_d;
    logic                    data_valid_q, data_valid_d;
    logic                    repeat_valid_q, repeat_valid_d;
    logic                    frame_err_q, frame_err_d;

    int   cnt_i;
    logic frame_ok;
    logic err;
    logic bit_val;
    logic bit_ok;

    assign cnt_i = int'(cnt_q);

    // Duration counter: edges restart it (a coincident tick is dropped), else saturating tick count
    always_comb begin
        cnt_d = cnt_q;
        if (rise || fall) begin
            cnt_d = '0;
        end else if (tick && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Integrity check on the assembled frame (inverse bytes when enabled)
    always_comb begin
`ifdef NEC_CHECK_EN
        frame_ok = (sh_q[15:8] == ~sh_q[7:0]) && (sh_q[31:24] == ~sh_q[23:16]);
`else
        frame_ok = 1'b1;
`endif
    end

    // Protocol FSM: edge classification, bit assembly, result pulses
    always_comb begin
        state_d        = state_q;
        bit_idx_d      = bit_idx_q;
        sh_d           = sh_q;
        rpt_d          = rpt_q;
        have_frame_d   = have_frame_q;
        addr_d         = addr_q;
        cmd_d          = cmd_q;
        data_valid_d   = 1'b0;
        repeat_valid_d = 1'b0;
        frame_err_d    = 1'b0;
        err            = 1'b0;
        bit_val        = 1'b0;
        bit_ok         = 1'b0;

        case (state_q)
            IDLE: begin
                // Only a fresh high-to-low transition arms a frame
                if (fall && !line_lvl) begin
                    state_d = LEAD_LOW;
                end
            end
            LEAD_LOW: begin
                if (rise) begin
                    if (in_win(cnt_i, LEAD_LOW_MIN, LEAD_LOW_MAX)) state_d = LEAD_HIGH;
                    else                                         err     = 1'b1;
                end else if (cnt_i > LEAD_LOW_MAX) begin
                    err = 1'b1;
                end
            end
            LEAD_HIGH: begin
                if (fall) begin
                    if (in_win(cnt_i, LEAD_HIGH_MIN, LEAD_HIGH_MAX)) begin
                        state_d   = BIT_LOW;
                        bit_idx_d = '0;
                        rpt_d     = 1'b0;
                    end else if (in_win(cnt_i, RPT_HIGH_MIN, RPT_HIGH_MAX)) begin
                        state_d = STOP;
                        rpt_d   = 1'b1;
                    end else begin
                        err = 1'b1;
                    end
                end else if (cnt_i > LEAD_HIGH_LIMIT) begin
                    err = 1'b1;
                end
            end
            BIT_LOW: begin
                if (rise) begin
                    if (in_win(cnt_i, BIT_LOW_MIN, BIT_LOW_MAX)) state_d = BIT_HIGH;
                    else                                       err     = 1'b1;
                end else if (cnt_i > BIT_LOW_MAX) begin
                    err = 1'b1;
                end
            end
            BIT_HIGH: begin
                if (fall) begin
                    if (in_win(cnt_i, ZERO_HIGH_MIN, ZERO_HIGH_MAX)) begin
                        bit_val = 1'b0;
                        bit_ok  = 1'b1;
                    end else if (in_win(cnt_i, ONE_HIGH_MIN, ONE_HIGH_MAX)) begin
                        bit_val = 1'b1;
                        bit_ok  = 1'b1;
                    end else begin
                        err = 1'b1;
                    end
                    if (bit_ok) begin
                        // NEC sends LSB first, so new bits enter at the top
                        sh_d = {bit_val, sh_q[FRAME_BITS-1:1]};
                        if (bit_idx_q == IDX_W'(FRAME_BITS - 1)) begin
                            state_d = STOP;
                        end else begin
                            bit_idx_d = bit_idx_q + 1'b1;
                            state_d   = BIT_LOW;
                        end
                    end
                end else if (cnt_i > BIT_HIGH_LIMIT) begin
                    err = 1'b1;
                end
            end
            STOP: begin
                if (rise) begin
                    state_d = IDLE;
                    if (!in_win(cnt_i, BIT_LOW_MIN, BIT_LOW_MAX)) begin
                        frame_err_d = 1'b1;
                    end else if (rpt_q) begin
                        // A repeat is only meaningful once a frame has been accepted
                        if (have_frame_q) repeat_valid_d = 1'b1;
                        else              frame_err_d    = 1'b1;
                    end else if (frame_ok) begin
                        addr_d       = sh_q[7:0];
                        cmd_d        = sh_q[23:16];
                        data_valid_d = 1'b1;
                        have_frame_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end else if (cnt_i > BIT_LOW_MAX) begin
                    err = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Any timing violation abandons the frame; decoded outputs are kept
        if (err) begin
            frame_err_d = 1'b1;
            state_d     = IDLE;
        end
    end

    // State, datapath and registered output flops
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            bit_idx_q      <= '0;
            sh_q           <= '0;
            rpt_q          <= 1'b0;
            have_frame_q   <= 1'b0;
            addr_q         <= '0;
            cmd_q          <= '0;
            data_valid_q   <= 1'b0;
            repeat_valid_q <= 1'b0;
            frame_err_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            bit_idx_q      <= bit_idx_d;
            sh_q           <= sh_d;
            rpt_q          <= rpt_d;
            have_frame_q   <= have_frame_d;
            addr_q         <= addr_d;
            cmd_q          <= cmd_d;
            data_valid_q   <= data_valid_d;
            repeat_valid_q <= repeat_valid_d;
            frame_err_q    <= frame_err_d;
        end
    end

    assign addr         = addr_q;
    assign cmd          = cmd_q;
    assign data_valid   = data_valid_q;
    assign repeat_valid = repeat_valid_q;
    assign frame_err    = frame_err_q;

endmodule

// File: tb/tb_nec_ir_decoder.sv
// Directed bench for nec_ir_decoder. Ticks are generated every 4 clk by the
// stimulus itself so IR edges keep a fixed phase relative to tick; widths
// passed to hold() are therefore exact tick counts as seen by the decoder.
module tb_nec_ir_decoder;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick;
    logic       ir_in;
    logic [7:0] addr;
    logic [7:0] cmd;
    logic       data_valid;
    logic       repeat_valid;
    logic       frame_err;

    int ph;
    int n_cmp;
    int n_err;
    int dv_n, rv_n, fe_n, viol_n;
    int dv0, rv0, fe0;
    int prev_any;

    nec_ir_decoder dut (
        .clk          (clk),
        .rst          (rst),
        .tick         (tick),
        .ir_in        (ir_in),
        .addr         (addr),
        .cmd          (cmd),
        .data_valid   (data_valid),
        .repeat_valid (repeat_valid),
        .frame_err    (frame_err)
    );

    always #5 clk = ~clk;

    // Pulse counters plus one-cycle-width and mutual-exclusion bookkeeping
    always @(negedge clk) begin
        int any;
        any = int'(data_valid) + int'(repeat_valid) + int'(frame_err);
        if (data_valid)   dv_n++;
        if (repeat_valid) rv_n++;
        if (frame_err)    fe_n++;
        if (any > 1) viol_n++;
        if ((any > 0) && (prev_any > 0)) viol_n++;
        prev_any = any;
    end

    task automatic step();
        @(negedge clk);
        ph   = (ph + 1) % 4;
        tick = (ph == 0);
    endtask

    task automatic align();
        do step(); while (tick !== 1'b1);
    endtask

    task automatic hold(input logic lvl, input int n);
        ir_in = lvl;
        repeat (4 * n) step();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        dv0 = dv_n;
        rv0 = rv_n;
        fe0 = fe_n;
    endtask

    // Leader then nbits data bits; bit odd_bit gets space odd_space ticks
    task automatic send_frame(input logic [31:0] word, input int nbits,
                              input int odd_bit, input int odd_space, input bit with_stop);
        align();
        hold(1'b0, 257);
        hold(1'b1, 128);
        for (int i = 0; i < nbits; i++) begin
            hold(1'b0, 16);
            hold(1'b1, (i == odd_bit) ? odd_space : (word[i] ? 48 : 16));
        end
        if (with_stop) begin
            hold(1'b0, 16);
            ir_in = 1'b1;
        end
    endtask

    task automatic send_repeat();
        align();
        hold(1'b0, 257);
        hold(1'b1, 64);
        hold(1'b0, 16);
        hold(1'b1, 20);
    endtask

    initial begin
        rst = 1'b1; tick = 1'b0; ir_in = 1'b1; ph = 0;
        n_cmp = 0; n_err = 0; dv_n = 0; rv_n = 0; fe_n = 0; viol_n = 0; prev_any = 0;

        repeat (8) step();
        check("rst_addr", addr, 0);
        check("rst_cmd", cmd, 0);
        check("rst_dv", data_valid, 0);
        check("rst_rv", repeat_valid, 0);
        check("rst_fe", frame_err, 0);
        rst = 1'b0;
        repeat (4) step();

        // Repeat code with no prior frame
        snap(); send_repeat();
        check("rpt_noframe_fe", fe_n - fe0, 1);
        check("rpt_noframe_rv", rv_n - rv0, 0);

        // Valid frame 00 FF 45 BA, with output latency from the stop rise
        snap(); send_frame(32'hBA45FF00, 32, -1, 0, 1'b1);
        step(); step();
        check("dv_lat_early", data_valid, 0);
        step();
        check("dv_lat_edge", data_valid, 1);
        step();
        check("dv_lat_after", data_valid, 0);
        hold(1'b1, 20);
        check("f1_addr", addr, 8'h00);
        check("f1_cmd", cmd, 8'h45);
        check("f1_dv", dv_n - dv0, 1);
        check("f1_fe", fe_n - fe0, 0);

        // Repeat after a valid frame
        snap(); send_repeat();
        check("rpt_rv", rv_n - rv0, 1);
        check("rpt_fe", fe_n - fe0, 0);
        check("rpt_addr", addr, 8'h00);
        check("rpt_cmd", cmd, 8'h45);

        // Second frame with distinct values
        snap(); send_frame(32'hEE11FE01, 32, -1, 0, 1'b1); hold(1'b1, 20);
        check("f2_dv", dv_n - dv0, 1);
        check("f2_addr", addr, 8'h01);
        check("f2_cmd", cmd, 8'h11);

        // Command inverse byte wrong (BB instead of BA)
        snap(); send_frame(32'hBB45FF00, 32, -1, 0, 1'b1); hold(1'b1, 20);
`ifdef NEC_CHECK_EN
        check("inv_fe", fe_n - fe0, 1);
        check("inv_dv", dv_n - dv0, 0);
        check("inv_addr", addr, 8'h01);
        check("inv_cmd", cmd, 8'h11);
`else
        check("inv_fe", fe_n - fe0, 0);
        check("inv_dv", dv_n - dv0, 1);
        check("inv_addr", addr, 8'h00);
        check("inv_cmd", cmd, 8'h45);
`endif

        // Leader low held far too long: error once the count passes 290
        snap(); align();
        hold(1'b0, 290);
        check("to_early_fe", fe_n - fe0, 0);
        hold(1'b0, 10);
        check("to_fe", fe_n - fe0, 1);
        hold(1'b1, 60);
        check("to_quiet_fe", fe_n - fe0, 1);
        check("to_quiet_dv", dv_n - dv0, 0);

        // Bit 3 space of 24 ticks still decodes as 0
        snap(); send_frame(32'hBA45FF00, 32, 3, 24, 1'b1); hold(1'b1, 20);
        check("sp24_dv", dv_n - dv0, 1);
        check("sp24_fe", fe_n - fe0, 0);
        check("sp24_addr", addr, 8'h00);
        check("sp24_cmd", cmd, 8'h45);

        // Bit 3 space of 25 ticks is rejected at the following fall
        snap(); send_frame(32'hBA45FF00, 4, 3, 25, 1'b0);
        hold(1'b0, 16);
        hold(1'b1, 60);
        check("sp25_fe", fe_n - fe0, 1);
        check("sp25_dv", dv_n - dv0, 0);

        // Reset during the burst of bit 12
        snap(); send_frame(32'hBA45FF00, 12, -1, 0, 1'b0);
        hold(1'b0, 8);
        rst = 1'b1;
        repeat (4) step();
        check("mrst_addr", addr, 0);
        check("mrst_cmd", cmd, 0);
        ir_in = 1'b1;
        repeat (4) step();
        rst = 1'b0;
        hold(1'b1, 20);
        check("mrst_pulses", (dv_n - dv0) + (rv_n - rv0) + (fe_n - fe0), 0);

        // Reset forgot the previous frame, so a repeat is an error
        snap(); send_repeat();
        check("mrst_rpt_fe", fe_n - fe0, 1);
        check("mrst_rpt_rv", rv_n - rv0, 0);

        // Full frame after reset decodes
        snap(); send_frame(32'hEE11FE01, 32, -1, 0, 1'b1); hold(1'b1, 20);
        check("post_dv", dv_n - dv0, 1);
        check("post_fe", fe_n - fe0, 0);
        check("post_addr", addr, 8'h01);
        check("post_cmd", cmd, 8'h11);

        check("pulse_shape", viol_n, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
